// File: rtl/sa_xaddr_arbiter_if.sv
// Address-channel bundle between the master-side dispatchers, the per-slave
// address arbiter and the slave port. The arbiter connects through the slave modport.
interface sa_xaddr_arbiter_if #(
   parameter int MST_AMT           = 2,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3,
   parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
   parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
);
   logic [TRANS_MST_ID_W*MST_AMT-1:0]    m_AxID_i;
   logic [ADDR_WIDTH*MST_AMT-1:0]        m_AxADDR_i;
   logic [TRANS_BURST_W*MST_AMT-1:0]     m_AxBURST_i;
   logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  m_AxLEN_i;
   logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] m_AxSIZE_i;
   logic [MST_AMT-1:0]                   m_AxVALID_i;
   logic [MST_AMT-1:0]                   m_Ax_outst_full_i;
   logic [MST_AMT-1:0]                   m_AxREADY_o;
   logic [TRANS_SLV_ID_W-1:0]            s_AxID_o;
   logic [ADDR_WIDTH-1:0]                s_AxADDR_o;
   logic [TRANS_BURST_W-1:0]             s_AxBURST_o;
   logic [TRANS_DATA_LEN_W-1:0]          s_AxLEN_o;
   logic [TRANS_DATA_SIZE_W-1:0]         s_AxSIZE_o;
   logic                                 s_AxVALID_o;
   logic                                 s_AxREADY_i;
   logic                                 s_xVALID_i;
   logic                                 s_xREADY_i;
   logic [MST_ID_W-1:0]                  xDATA_mst_id_o;
   logic                                 xDATA_disable_o;
   logic                                 outst_full_o;

   modport slave (
      input  m_AxID_i, m_AxADDR_i, m_AxBURST_i, m_AxLEN_i, m_AxSIZE_i,
      input  m_AxVALID_i, m_Ax_outst_full_i, s_AxREADY_i, s_xVALID_i, s_xREADY_i,
      output m_AxREADY_o, s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o,
      output s_AxVALID_o, xDATA_mst_id_o, xDATA_disable_o, outst_full_o
   );

   modport master (
      output m_AxID_i, m_AxADDR_i, m_AxBURST_i, m_AxLEN_i, m_AxSIZE_i,
      output m_AxVALID_i, m_Ax_outst_full_i, s_AxREADY_i, s_xVALID_i, s_xREADY_i,
      input  m_AxREADY_o, s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o,
      input  s_AxVALID_o, xDATA_mst_id_o, xDATA_disable_o, outst_full_o
   );
endinterface

// File: rtl/sa_xaddr_arbiter.sv
// Per-slave Ax arbiter with registered output stage and {master, AxLEN} order FIFO.
// Optional SA_XADDR_ROUND_ROBIN_EN: round-robin instead of fixed lowest-index priority.
module sa_xaddr_arbiter #(
   parameter int MST_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3,
   parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
   parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
   input logic               ACLK_i,
   input logic               ARESETn_i,
   sa_xaddr_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(OUTSTANDING_AMT);
   localparam int OCC_W = PTR_W + 1;

   logic [MST_AMT-1:0]           req_s;
   logic [MST_AMT-1:0]           grant_vec_s;
   logic [MST_ID_W-1:0]          start_idx_s;
   logic [MST_ID_W-1:0]          cand_idx_s;
   logic [MST_ID_W-1:0]          gnt_idx_s;
   logic                         gnt_found_s;
   logic                         ld_ok_s;
   logic                         grant_s;
   logic                         fifo_empty_s;
   logic                         fifo_full_s;
   logic                         beat_s;
   logic                         pop_s;

   logic                         s_valid_r;
   logic [TRANS_SLV_ID_W-1:0]    s_id_r;
   logic [ADDR_WIDTH-1:0]        s_addr_r;
   logic [TRANS_BURST_W-1:0]     s_burst_r;
   logic [TRANS_DATA_LEN_W-1:0]  s_len_r;
   logic [TRANS_DATA_SIZE_W-1:0] s_size_r;

   logic [MST_ID_W-1:0]          fifo_id_r  [OUTSTANDING_AMT];
   logic [TRANS_DATA_LEN_W-1:0]  fifo_len_r [OUTSTANDING_AMT];
   logic [PTR_W-1:0]             wr_ptr_r;
   logic [PTR_W-1:0]             rd_ptr_r;
   logic [OCC_W-1:0]             occ_r;
   logic [TRANS_DATA_LEN_W-1:0]  beat_cnt_r;

   assign req_s        = bus.m_AxVALID_i & ~bus.m_Ax_outst_full_i;
   assign fifo_empty_s = (occ_r == OCC_W'(0));
   assign fifo_full_s  = (occ_r == OCC_W'(OUTSTANDING_AMT));
   // A full FIFO blocks the grant even when a pop lands in the same cycle.
   assign ld_ok_s      = (~s_valid_r | bus.s_AxREADY_i) & ~fifo_full_s;
   assign grant_s      = ld_ok_s & gnt_found_s;

`ifdef SA_XADDR_ROUND_ROBIN_EN
   logic [MST_ID_W-1:0] rr_ptr_r;

   assign start_idx_s = rr_ptr_r;

   // Round-robin pointer: one past the last winner.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         rr_ptr_r <= MST_ID_W'(0);
      end else if (grant_s) begin
         rr_ptr_r <= (gnt_idx_s == MST_ID_W'(MST_AMT - 1)) ? MST_ID_W'(0) : gnt_idx_s + MST_ID_W'(1);
      end
   end
`else
   assign start_idx_s = MST_ID_W'(0);
`endif

   // Winner search: first eligible request at or after start_idx_s.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = MST_ID_W'(0);
      cand_idx_s  = MST_ID_W'(0);
      for (int k = 0; k < MST_AMT; k++) begin
         cand_idx_s = MST_ID_W'((int'(start_idx_s) + k) % MST_AMT);
         if (req_s[cand_idx_s] && !gnt_found_s) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_idx_s;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // One-hot master handshake for the winner.
   always_comb begin
      grant_vec_s = {MST_AMT{1'b0}};
      if (grant_s) begin
         grant_vec_s[gnt_idx_s] = 1'b1;
      end else begin
         grant_vec_s = {MST_AMT{1'b0}};
      end
   end

   // Output stage: load on grant, drop valid after an unreplaced slave handshake.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         s_valid_r <= 1'b0;
         s_id_r    <= TRANS_SLV_ID_W'(0);
         s_addr_r  <= ADDR_WIDTH'(0);
         s_burst_r <= TRANS_BURST_W'(0);
         s_len_r   <= TRANS_DATA_LEN_W'(0);
         s_size_r  <= TRANS_DATA_SIZE_W'(0);
      end else if (grant_s) begin
         s_valid_r <= 1'b1;
         s_id_r    <= {gnt_idx_s, bus.m_AxID_i[int'(gnt_idx_s)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
         s_addr_r  <= bus.m_AxADDR_i[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
         s_burst_r <= bus.m_AxBURST_i[int'(gnt_idx_s)*TRANS_BURST_W +: TRANS_BURST_W];
         s_len_r   <= bus.m_AxLEN_i[int'(gnt_idx_s)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
         s_size_r  <= bus.m_AxSIZE_i[int'(gnt_idx_s)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end else if (bus.s_AxREADY_i) begin
         s_valid_r <= 1'b0;
      end
   end

   // Beats seen while no burst is recorded are dropped.
   assign beat_s = bus.s_xVALID_i & bus.s_xREADY_i & ~fifo_empty_s;
   assign pop_s  = beat_s & (beat_cnt_r == fifo_len_r[rd_ptr_r]);

   // Order FIFO storage; validity is tracked by occ_r, so no reset needed.
   always_ff @(posedge ACLK_i) begin
      if (grant_s) begin
         fifo_id_r[wr_ptr_r]  <= gnt_idx_s;
         fifo_len_r[wr_ptr_r] <= bus.m_AxLEN_i[int'(gnt_idx_s)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      end
   end

   // Order FIFO pointers, occupancy and beat counter.
   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         wr_ptr_r   <= PTR_W'(0);
         rd_ptr_r   <= PTR_W'(0);
         occ_r      <= OCC_W'(0);
         beat_cnt_r <= TRANS_DATA_LEN_W'(0);
      end else begin
         if (grant_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({grant_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1);
            2'b01:   occ_r <= occ_r - OCC_W'(1);
            default: occ_r <= occ_r;
         endcase
         if (pop_s)       beat_cnt_r <= TRANS_DATA_LEN_W'(0);
         else if (beat_s) beat_cnt_r <= beat_cnt_r + TRANS_DATA_LEN_W'(1);
      end
   end

   assign bus.m_AxREADY_o     = grant_vec_s;
   assign bus.s_AxVALID_o     = s_valid_r;
   assign bus.s_AxID_o        = s_id_r;
   assign bus.s_AxADDR_o      = s_addr_r;
   assign bus.s_AxBURST_o     = s_burst_r;
   assign bus.s_AxLEN_o       = s_len_r;
   assign bus.s_AxSIZE_o      = s_size_r;
   assign bus.xDATA_mst_id_o  = fifo_empty_s ? MST_ID_W'(0) : fifo_id_r[rd_ptr_r];
   assign bus.xDATA_disable_o = fifo_empty_s;
   assign bus.outst_full_o    = fifo_full_s;
endmodule

// File: tb/tb_sa_xaddr_arbiter.sv
// Directed self-checking bench for sa_xaddr_arbiter (default parameters).
module tb_sa_xaddr_arbiter;
   localparam int IW = 5;
   localparam int AW = 32;
   localparam int BW = 2;
   localparam int LW = 3;
   localparam int SW = 3;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   logic [1:0] exp_gnt;

   sa_xaddr_arbiter_if bus ();

   sa_xaddr_arbiter dut (
      .ACLK_i    (clk),
      .ARESETn_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int i, input logic [4:0] id, input logic [31:0] addr, input logic [2:0] len);
      bus.m_AxID_i[i*IW +: IW]    = id;
      bus.m_AxADDR_i[i*AW +: AW]  = addr;
      bus.m_AxBURST_i[i*BW +: BW] = 2'b01;
      bus.m_AxLEN_i[i*LW +: LW]   = len;
      bus.m_AxSIZE_i[i*SW +: SW]  = 3'd2;
   endtask

   task automatic beats(input logic on);
      bus.s_xVALID_i = on;
      bus.s_xREADY_i = on;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.m_AxID_i          = '0;
      bus.m_AxADDR_i        = '0;
      bus.m_AxBURST_i       = '0;
      bus.m_AxLEN_i         = '0;
      bus.m_AxSIZE_i        = '0;
      bus.m_AxVALID_i       = 2'b00;
      bus.m_Ax_outst_full_i = 2'b00;
      bus.s_AxREADY_i       = 1'b1;
      bus.s_xVALID_i        = 1'b0;
      bus.s_xREADY_i        = 1'b0;
      #12;
      chk("rst_svalid", bus.s_AxVALID_o, 1'b0);
      chk("rst_mready", bus.m_AxREADY_o, 2'b00);
      chk("rst_disable", bus.xDATA_disable_o, 1'b1);
      chk("rst_full", bus.outst_full_o, 1'b0);
      chk("rst_mstid", bus.xDATA_mst_id_o, 1'b0);
      chk("rst_addr", bus.s_AxADDR_o, 32'h0);
      cyc();
      rst_n = 1'b1;

      // Beat on empty FIFO must be ignored.
      beats(1'b1);
      cyc();
      beats(1'b0);
      #1;
      chk("empty_beat_disable", bus.xDATA_disable_o, 1'b1);

      // Single request from master 1.
      set_m(1, 5'd3, 32'h4000_0010, 3'd3);
      bus.m_AxVALID_i = 2'b10;
      #1;
      chk("single_gnt", bus.m_AxREADY_o, 2'b10);
      cyc();
      bus.m_AxVALID_i = 2'b00;
      #1;
      chk("single_svalid", bus.s_AxVALID_o, 1'b1);
      chk("single_sid", bus.s_AxID_o, 6'h23);
      chk("single_addr", bus.s_AxADDR_o, 32'h4000_0010);
      chk("single_len", bus.s_AxLEN_o, 3'd3);
      chk("single_burst", bus.s_AxBURST_o, 2'b01);
      chk("single_size", bus.s_AxSIZE_o, 3'd2);
      chk("single_mstid", bus.xDATA_mst_id_o, 1'b1);
      chk("single_disable", bus.xDATA_disable_o, 1'b0);
      cyc();
      chk("single_svalid_drop", bus.s_AxVALID_o, 1'b0);
      beats(1'b1);
      repeat (3) cyc();
      chk("single_3beats", bus.xDATA_disable_o, 1'b0);
      cyc();
      beats(1'b0);
      chk("single_4beats", bus.xDATA_disable_o, 1'b1);

      // Contention, slave always ready.
      set_m(0, 5'd5, 32'h0000_1000, 3'd0);
      set_m(1, 5'd6, 32'h0000_2000, 3'd0);
      bus.m_AxVALID_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef SA_XADDR_ROUND_ROBIN_EN
         exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_gnt = 2'b01;
`endif
         #1;
         chk("contend_gnt", bus.m_AxREADY_o, exp_gnt);
         cyc();
      end
      bus.m_AxVALID_i = 2'b00;
`ifdef SA_XADDR_ROUND_ROBIN_EN
      chk("contend_sid", bus.s_AxID_o, 6'h26);
`else
      chk("contend_sid", bus.s_AxID_o, 6'h05);
`endif
      beats(1'b1);
      repeat (3) cyc();
      chk("contend_3pops", bus.xDATA_disable_o, 1'b0);
      cyc();
      beats(1'b0);
      chk("contend_4pops", bus.xDATA_disable_o, 1'b1);
      chk("contend_svalid", bus.s_AxVALID_o, 1'b0);

      // Slave stall: payload held, no second grant.
      bus.s_AxREADY_i = 1'b0;
      set_m(0, 5'd7, 32'hAAAA_0000, 3'd1);
      bus.m_AxVALID_i = 2'b01;
      #1;
      chk("stall_gnt", bus.m_AxREADY_o, 2'b01);
      cyc();
      set_m(0, 5'd8, 32'hBBBB_0000, 3'd1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_mready", bus.m_AxREADY_o, 2'b00);
         chk("stall_addr", bus.s_AxADDR_o, 32'hAAAA_0000);
         chk("stall_svalid", bus.s_AxVALID_o, 1'b1);
         cyc();
      end
      bus.m_AxVALID_i = 2'b00;
      bus.s_AxREADY_i = 1'b1;
      cyc();
      chk("stall_release", bus.s_AxVALID_o, 1'b0);
      beats(1'b1);
      cyc();
      chk("stall_1beat", bus.xDATA_disable_o, 1'b0);
      cyc();
      beats(1'b0);
      chk("stall_single_push", bus.xDATA_disable_o, 1'b1);

      // Fill the order FIFO.
      set_m(0, 5'd1, 32'h0000_0100, 3'd0);
      bus.m_AxVALID_i = 2'b01;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("fill_gnt", bus.m_AxREADY_o, 2'b01);
         cyc();
      end
      #1;
      chk("full_flag", bus.outst_full_o, 1'b1);
      chk("full_block", bus.m_AxREADY_o, 2'b00);
      cyc();
      chk("full_no9th", bus.s_AxVALID_o, 1'b0);
      beats(1'b1);
      #1;
      chk("full_block_on_pop", bus.m_AxREADY_o, 2'b00);
      cyc();
      beats(1'b0);
      #1;
      chk("full_clear", bus.outst_full_o, 1'b0);
      chk("full_resume", bus.m_AxREADY_o, 2'b01);
      bus.m_AxVALID_i = 2'b00;
      beats(1'b1);
      repeat (7) cyc();
      beats(1'b0);
      chk("full_drained", bus.xDATA_disable_o, 1'b1);

      // Masking by dispatcher full.
      bus.m_Ax_outst_full_i = 2'b01;
      bus.m_AxVALID_i = 2'b11;
      #1;
      chk("mask_gnt", bus.m_AxREADY_o, 2'b10);
      bus.m_AxVALID_i = 2'b00;
      bus.m_Ax_outst_full_i = 2'b00;
      cyc();

      // Async reset mid-burst with counter at 2.
      bus.s_AxREADY_i = 1'b0;
      set_m(1, 5'd9, 32'h0000_0055, 3'd3);
      bus.m_AxVALID_i = 2'b10;
      #1;
      chk("mid_gnt", bus.m_AxREADY_o, 2'b10);
      cyc();
      bus.m_AxVALID_i = 2'b00;
      beats(1'b1);
      repeat (2) cyc();
      beats(1'b0);
      chk("mid_pending", bus.xDATA_disable_o, 1'b0);
      chk("mid_svalid", bus.s_AxVALID_o, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_svalid", bus.s_AxVALID_o, 1'b0);
      chk("arst_addr", bus.s_AxADDR_o, 32'h0);
      chk("arst_sid", bus.s_AxID_o, 6'h00);
      chk("arst_disable", bus.xDATA_disable_o, 1'b1);
      chk("arst_mstid", bus.xDATA_mst_id_o, 1'b0);
      chk("arst_full", bus.outst_full_o, 1'b0);
      cyc();
      rst_n = 1'b1;
      bus.s_AxREADY_i = 1'b1;
      cyc();
      chk("post_rst_disable", bus.xDATA_disable_o, 1'b1);
      set_m(0, 5'd2, 32'h0000_0400, 3'd1);
      bus.m_AxVALID_i = 2'b01;
      cyc();
      bus.m_AxVALID_i = 2'b00;
      chk("post_rst_mstid", bus.xDATA_mst_id_o, 1'b0);
      beats(1'b1);
      cyc();
      chk("post_rst_cnt1", bus.xDATA_disable_o, 1'b0);
      cyc();
      beats(1'b0);
      chk("post_rst_cnt0", bus.xDATA_disable_o, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
